// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, control-bundle types and FSM states for decode_stage.
// Optional feature macro: DECODE_STAGE_ILLEGAL_TRAP_EN (adds the HALT state).
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_CMP   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    logic        alu_a_pc;
    logic        is_load;
    logic        branch;
    logic        jump;
    logic        jalr;
    result_src_t result_src;
    imm_src_t    imm_src;
    alu_op_t     alu_op;
    logic [2:0]  branch_cond;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
    , ST_HALT = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/decode_table.sv
// decode_table: combinational RV32I opcode decode into the control bundle.
// Only instr[14:0] matter here (opcode, rd, funct3); funct7 and source
// fields are decoded downstream from the registered instruction word.
// Optional feature macro: DECODE_STAGE_ILLEGAL_TRAP_EN (adds the legal output).
module decode_table
  import decode_pkg::*;
(
  input  logic [14:0] instr,
  output ctrl_t       ctrl,
  output logic        uses_rs1,
  output logic        uses_rs2
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
  , output logic      legal
`endif
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];

`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
  // Every known opcode has [1:0] == 2'b11, so this also covers compressed words.
  assign legal = opcode inside {OP_R, OP_LOAD, OP_IALU, OP_STORE, OP_BRANCH,
                                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
`endif

  // Opcode to control flags and source-register usage.
  always_comb begin
    ctrl     = CTRL_NOP;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.is_load    = 1'b1;
        ctrl.imm_src    = IMM_I;
        uses_rs1        = 1'b1;
      end
      OP_IALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
        ctrl.imm_src   = IMM_I;
        uses_rs1       = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_op      = ALU_CMP;
        ctrl.imm_src     = IMM_B;
        ctrl.branch_cond = funct3;
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.imm_src    = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.imm_src    = IMM_I;
        uses_rs1        = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_IMM;
        ctrl.imm_src    = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_a_pc  = 1'b1;
        ctrl.imm_src   = IMM_U;
      end
      default: ctrl = CTRL_NOP;
    endcase
    if (rd == '0) begin
      ctrl.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked RV32I decode stage (ID/EX control
// register) with parametrised load-use bubbles and flush.
// Optional feature macro: DECODE_STAGE_ILLEGAL_TRAP_EN (illegal-instruction
// trap: sticky out_illegal and a HALT state left only by flush).
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned D_WIDTH          = 32,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_reg_write,
  output logic               out_mem_write,
  output logic               out_alu_src,
  output logic               out_alu_a_pc,
  output logic               out_is_load,
  output logic               out_branch,
  output logic               out_jump,
  output logic               out_jalr,
  output logic [1:0]         out_result_src,
  output logic [2:0]         out_imm_src,
  output logic [1:0]         out_alu_op,
  output logic [2:0]         out_branch_cond,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [31:0]        out_instr,
  output logic               out_illegal
);

  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_BUBBLES - 1);

  logic [31:0] word;
  ctrl_t       dec_ctrl;
  logic        uses_rs1;
  logic        uses_rs2;

  state_t      state;
  state_t      state_n;
  logic [1:0]  cnt;
  logic [1:0]  cnt_n;

  logic        valid_q;
  ctrl_t       ctrl_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [31:0] instr_q;

  logic        adv;
  logic        hazard;
  logic        take;
  logic        bubble;

  assign word = instr[31:0];

`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
  logic legal;
  logic trap;
  logic illegal_q;

  decode_table u_table (
    .instr    (word[14:0]),
    .ctrl     (dec_ctrl),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .legal    (legal)
  );
`else
  decode_table u_table (
    .instr    (word[14:0]),
    .ctrl     (dec_ctrl),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );
`endif

  assign adv    = !valid_q || out_ready;
  assign hazard = in_valid && valid_q && ctrl_q.is_load && (rd_q != '0) &&
                  ((uses_rs1 && (word[19:15] == rd_q)) ||
                   (uses_rs2 && (word[24:20] == rd_q)));

  // FSM state and bubble counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, handshake and register-load decision; flush overrides all.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    in_ready = 1'b0;
    take     = 1'b0;
    bubble   = 1'b0;
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
    trap     = 1'b0;
`endif
    if (flush) begin
      state_n = ST_RUN;
      cnt_n   = '0;
      bubble  = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          in_ready = adv && !hazard;
          if (adv) begin
            if (hazard) begin
              bubble = 1'b1;
              cnt_n  = CNT_INIT;
              if (CNT_INIT != '0) begin
                state_n = ST_STALL;
              end
            end else if (in_valid) begin
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
              if (legal) begin
                take = 1'b1;
              end else begin
                bubble  = 1'b1;
                trap    = 1'b1;
                state_n = ST_HALT;
              end
`else
              take = 1'b1;
`endif
            end else begin
              bubble = 1'b1;
            end
          end
        end
        // The hazard edge already produced the first bubble, so leaving
        // when the decremented count reaches zero yields exactly
        // LOAD_USE_BUBBLES invalid cycles before the dependent is accepted.
        ST_STALL: begin
          if (adv) begin
            bubble = 1'b1;
            cnt_n  = (cnt == '0) ? '0 : cnt - 2'd1;
            if (cnt_n == '0) begin
              state_n = ST_RUN;
            end
          end
        end
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
        ST_HALT: begin
          if (adv) begin
            bubble = 1'b1;
          end
        end
`endif
        default: begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // ID/EX control register: load on accept, clear controls on a bubble, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      instr_q <= '0;
    end else if (take) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec_ctrl;
      rd_q    <= word[11:7];
      rs1_q   <= word[19:15];
      rs2_q   <= word[24:20];
      instr_q <= word;
    end else if (bubble) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
    end
  end

`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
  // Sticky illegal flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (trap) begin
      illegal_q <= 1'b1;
    end
  end

  assign out_illegal = illegal_q;
`else
  assign out_illegal = 1'b0;
`endif

  assign out_valid       = valid_q;
  assign out_reg_write   = ctrl_q.reg_write;
  assign out_mem_write   = ctrl_q.mem_write;
  assign out_alu_src     = ctrl_q.alu_src;
  assign out_alu_a_pc    = ctrl_q.alu_a_pc;
  assign out_is_load     = ctrl_q.is_load;
  assign out_branch      = ctrl_q.branch;
  assign out_jump        = ctrl_q.jump;
  assign out_jalr        = ctrl_q.jalr;
  assign out_result_src  = ctrl_q.result_src;
  assign out_imm_src     = ctrl_q.imm_src;
  assign out_alu_op      = ctrl_q.alu_op;
  assign out_branch_cond = ctrl_q.branch_cond;
  assign out_rd          = rd_q;
  assign out_rs1         = rs1_q;
  assign out_rs2         = rs2_q;
  assign out_instr       = instr_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage with
// LOAD_USE_BUBBLES=2 against a transaction-level reference model.
module tb_decode_stage;

  localparam int NB  = 2;
  localparam int TXN = 300;

  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_ADD  = 32'h00228333;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_LUI0 = 32'h00001037;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_reg_write, out_mem_write, out_alu_src, out_alu_a_pc;
  logic        out_is_load, out_branch, out_jump, out_jalr;
  logic [1:0]  out_result_src;
  logic [2:0]  out_imm_src;
  logic [1:0]  out_alu_op;
  logic [2:0]  out_branch_cond;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_instr;
  logic        out_illegal;

  decode_stage #(.D_WIDTH(32), .LOAD_USE_BUBBLES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
    .out_alu_src(out_alu_src), .out_alu_a_pc(out_alu_a_pc),
    .out_is_load(out_is_load), .out_branch(out_branch), .out_jump(out_jump),
    .out_jalr(out_jalr), .out_result_src(out_result_src),
    .out_imm_src(out_imm_src), .out_alu_op(out_alu_op),
    .out_branch_cond(out_branch_cond), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_instr(out_instr), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       rw, mw, asrc, apc, ld, br, jmp, jr;
    logic [1:0] res;
    logic [2:0] imm;
    logic [1:0] aop;
    logic [2:0] cond;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
  } exp_t;

  // Reference decode written straight from the instruction-class table.
  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    e = '0;
    e.rd  = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    case (i[6:0])
      7'h33: begin e.rw = 1; e.aop = 2'b10; e.u1 = 1; e.u2 = 1; end
      7'h03: begin e.rw = 1; e.asrc = 1; e.res = 2'b01; e.ld = 1; e.u1 = 1; end
      7'h13: begin e.rw = 1; e.asrc = 1; e.aop = 2'b10; e.u1 = 1; end
      7'h23: begin e.mw = 1; e.asrc = 1; e.imm = 3'b001; e.u1 = 1; e.u2 = 1; end
      7'h63: begin
        e.br = 1; e.aop = 2'b01; e.imm = 3'b010; e.cond = i[14:12];
        e.u1 = 1; e.u2 = 1;
      end
      7'h6F: begin e.rw = 1; e.jmp = 1; e.res = 2'b10; e.imm = 3'b011; end
      7'h67: begin
        e.rw = 1; e.jmp = 1; e.jr = 1; e.asrc = 1; e.res = 2'b10; e.u1 = 1;
      end
      7'h37: begin e.rw = 1; e.res = 2'b11; e.imm = 3'b100; end
      7'h17: begin e.rw = 1; e.asrc = 1; e.apc = 1; e.imm = 3'b100; end
      default: ;
    endcase
    if (e.rd == 5'd0) e.rw = 0;
    return e;
  endfunction

  function automatic logic [32:0] ev(input exp_t e);
    return {e.rw, e.mw, e.asrc, e.apc, e.ld, e.br, e.jmp, e.jr,
            e.res, e.imm, e.aop, e.cond, e.rd, e.rs1, e.rs2};
  endfunction

  function automatic logic [32:0] obs_vec();
    return {out_reg_write, out_mem_write, out_alu_src, out_alu_a_pc,
            out_is_load, out_branch, out_jump, out_jalr, out_result_src,
            out_imm_src, out_alu_op, out_branch_cond, out_rd, out_rs1, out_rs2};
  endfunction

  function automatic logic [31:0] gen();
    logic [6:0] ops [9];
    logic [6:0] op;
    ops = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    op = ops[$urandom_range(0, 8)];
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "time limit");
  end

  exp_t        q [$];
  logic [31:0] iq [$];
  int          gq [$];
  exp_t        e;
  exp_t        last;
  bit          have_last;
  bit          held;
  bit          dep;
  bit          new_needed;
  int          gap;
  int          g;
  int          accepted;
  logic [32:0] snap;
  logic [31:0] snap_i;

  initial begin
    // Reset state
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_ctrl", obs_vec(), 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_illegal", out_illegal, 0);
    rst_n = 1'b1;
    tick();

    // Load-use: lw x5 then add x6,x5,x2 -> two bubbles
    in_valid = 1; instr = I_LW; out_ready = 1; #1;
    chk("lw_in_ready", in_ready, 1);
    tick(); instr = I_ADD; #1;
    chk("lw_out_valid", out_valid, 1);
    chk("lw_out", obs_vec(), ev(model(I_LW)));
    chk("hazard_in_ready", in_ready, 0);
    tick(); #1;
    chk("bubble1_valid", out_valid, 0);
    chk("bubble1_in_ready", in_ready, 0);
    tick(); #1;
    chk("bubble2_valid", out_valid, 0);
    chk("post_stall_in_ready", in_ready, 1);
    tick(); in_valid = 0; #1;
    chk("add_valid", out_valid, 1);
    chk("add_rs1", out_rs1, 5);
    chk("add_reg_write", out_reg_write, 1);
    chk("add_out", obs_vec(), ev(model(I_ADD)));
    tick();

    // Branch, then LUI to x0
    in_valid = 1; instr = I_BEQ; #1;
    chk("beq_in_ready", in_ready, 1);
    tick(); instr = I_LUI0; #1;
    chk("beq_valid", out_valid, 1);
    chk("beq_branch", out_branch, 1);
    chk("beq_cond", out_branch_cond, 0);
    chk("beq_imm_src", out_imm_src, 3'b010);
    chk("beq_reg_write", out_reg_write, 0);
    chk("beq_out", obs_vec(), ev(model(I_BEQ)));
    chk("beq_in_ready_next", in_ready, 1);
    tick(); in_valid = 0; #1;
    chk("lui_valid", out_valid, 1);
    chk("lui_reg_write", out_reg_write, 0);
    chk("lui_result_src", out_result_src, 2'b11);
    tick();

    // Flush during STALL
    in_valid = 1; instr = I_LW; #1;
    tick(); instr = I_ADD; #1;
    chk("fl_lw_valid", out_valid, 1);
    tick(); flush = 1; #1;
    chk("flush_cycle_in_ready", in_ready, 0);
    tick(); flush = 0; #1;
    chk("post_flush_valid", out_valid, 0);
    chk("post_flush_in_ready", in_ready, 1);
    chk("post_flush_instr", out_instr, I_LW);
    tick(); in_valid = 0; #1;
    chk("post_flush_add_valid", out_valid, 1);
    chk("post_flush_add_rd", out_rd, 6);
    tick();

    // Illegal instruction
    in_valid = 1; instr = I_BAD; #1;
    chk("bad_in_ready", in_ready, 1);
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
    tick(); instr = 32'h00000013; #1;
    chk("trap_valid", out_valid, 0);
    chk("trap_illegal", out_illegal, 1);
    chk("halt_in_ready", in_ready, 0);
    tick(); #1;
    chk("halt_in_ready2", in_ready, 0);
    flush = 1;
    tick(); flush = 0; #1;
    chk("unhalt_in_ready", in_ready, 1);
    chk("illegal_sticky", out_illegal, 1);
    in_valid = 0;
    tick(); tick();
`else
    tick(); in_valid = 0; #1;
    chk("bad_valid", out_valid, 1);
    chk("bad_ctrl_zero", obs_vec(), ev(model(I_BAD)));
    chk("bad_illegal", out_illegal, 0);
    tick();
`endif

    // Asynchronous reset mid-STALL
    in_valid = 1; instr = I_LW; #1;
    tick(); instr = I_ADD; #1;
    tick(); #2;
    rst_n = 0; #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ctrl", obs_vec(), 0);
    chk("arst_instr", out_instr, 0);
    rst_n = 1; #1;
    chk("arst_in_ready", in_ready, 1);
    tick(); in_valid = 0; #1;
    chk("arst_add_valid", out_valid, 1);
    chk("arst_add_out", obs_vec(), ev(model(I_ADD)));
    tick(); tick();

    // Randomized stream with random backpressure against the queue model
    have_last = 0; held = 0; gap = 0; accepted = 0; new_needed = 0;
    snap = '0; snap_i = '0;
    in_valid = 1; instr = gen(); out_ready = ($urandom_range(0, 3) != 0); #1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (out_valid) begin
        if (!held) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = q.pop_front();
            g = gq.pop_front();
            chk("stream_ctrl", obs_vec(), ev(e));
            chk("stream_instr", out_instr, iq.pop_front());
            if (g >= 0) chk("load_use_gap", gap, g);
          end
          snap = obs_vec();
          snap_i = out_instr;
        end else begin
          chk("hold_stable", {obs_vec(), out_instr}, {snap, snap_i});
        end
        gap = 0;
      end else begin
        gap++;
      end
      if (out_valid && !out_ready) chk("blocked_in_ready", in_ready, 0);
      held = out_valid && !out_ready;
      new_needed = 0;
      if (in_valid && in_ready) begin
        e = model(instr);
        dep = have_last && last.ld && (last.rd != 0) &&
              ((e.u1 && e.rs1 == last.rd) || (e.u2 && e.rs2 == last.rd));
        q.push_back(e);
        iq.push_back(instr);
        gq.push_back(have_last ? (dep ? NB : 0) : -1);
        last = e;
        have_last = 1;
        accepted++;
        new_needed = 1;
      end
      if (accepted >= TXN && q.size() == 0 && gap > 4) break;
      tick();
      if (new_needed) begin
        if (accepted < TXN) instr = gen();
        else in_valid = 0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
    end
    chk("stream_accepted", accepted, TXN);
    chk("stream_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
